// File: rtl/int_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_sync_pkg
// Purpose  : Shared constants and helpers for the interrupt sync crossing sink.
// Revision : 1.0 - initial release
// ============================================================================
package int_sync_pkg;

    localparam int SYNC_DEPTH_MIN = 2;
    localparam int SYNC_DEPTH_MAX = 4;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Index fields never collapse to zero width, even for a single line.
    function automatic int id_width(input int num);
        return (clog2(num) < 1) ? 1 : clog2(num);
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_sync_filt_line.sv
`default_nettype none
// ============================================================================
// Module   : int_sync_filt_line
// Purpose  : One interrupt line: flop synchronizer followed by a glitch filter.
// Revision : 1.0 - initial release
// ============================================================================
module int_sync_filt_line
    import int_sync_pkg::*;
#(
    parameter int SYNC_DEPTH  = 3,
    parameter int FILT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic sync_in,
    output logic filt
);

    localparam int c_depth = (SYNC_DEPTH < SYNC_DEPTH_MIN) ? SYNC_DEPTH_MIN :
                             (SYNC_DEPTH > SYNC_DEPTH_MAX) ? SYNC_DEPTH_MAX : SYNC_DEPTH;

    logic [c_depth-1:0] r_sync;
    logic               w_s;
    logic               r_filt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_depth-2:0], sync_in};
        end
    end

    assign w_s = r_sync[c_depth-1];

    generate
        if (FILT_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_filt <= 1'b0;
                end else begin
                    r_filt <= w_s;
                end
            end
        end else begin : g_filter
            localparam int              c_cw       = clog2(FILT_CYCLES + 1);
            localparam logic [c_cw-1:0] c_cnt_last = c_cw'(FILT_CYCLES - 1);

            logic [c_cw-1:0] r_cnt;

            // The counter tracks consecutive cycles that disagree with filt.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_filt <= 1'b0;
                    r_cnt  <= '0;
                end else if (w_s == r_filt) begin
                    r_cnt  <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_filt <= w_s;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/int_sync_crossing_sink_filt.sv
`default_nettype none
// ============================================================================
// Module   : int_sync_crossing_sink_filt
// Purpose  : Receive side of the interrupt crossing with glitch filtering,
//            level/edge line modes and a valid/ready claim port.
// Revision : 1.0 - initial release
// ============================================================================
module int_sync_crossing_sink_filt
    import int_sync_pkg::*;
#(
    parameter int                 NUM_INT     = 4,
    parameter int                 SYNC_DEPTH  = 3,
    parameter int                 FILT_CYCLES = 4,
    parameter logic [NUM_INT-1:0] EDGE_MASK   = {NUM_INT{1'b0}}
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_INT-1:0]            auto_in_sync,
    output logic [NUM_INT-1:0]            auto_out,
    output logic                          irq_valid,
    output logic [id_width(NUM_INT)-1:0]  irq_id,
    input  logic                          irq_ready
);

    localparam int c_id_w = id_width(NUM_INT);

    logic [NUM_INT-1:0] w_filt;
    logic [NUM_INT-1:0] w_out;
    logic [NUM_INT-1:0] w_claim;
    logic               w_valid;
    logic [c_id_w-1:0]  w_id;

    generate
        for (genvar i = 0; i < NUM_INT; i++) begin : g_line
            localparam logic c_edge = (EDGE_MASK[i] == MODE_EDGE);

            logic r_prev;
            logic r_pend;

            int_sync_filt_line #(
                .SYNC_DEPTH  (SYNC_DEPTH),
                .FILT_CYCLES (FILT_CYCLES)
            ) u_filt (
                .clock   (clock),
                .reset   (reset),
                .sync_in (auto_in_sync[i]),
                .filt    (w_filt[i])
            );

            assign w_claim[i] = w_valid && irq_ready && (w_id == c_id_w'(i));

            // A new rising edge outranks a claim in the same cycle so no edge is lost.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_prev <= 1'b0;
                    r_pend <= 1'b0;
                end else begin
                    r_prev <= w_filt[i];
                    r_pend <= c_edge & ((w_filt[i] & ~r_prev) | (r_pend & ~w_claim[i]));
                end
            end

            assign w_out[i] = c_edge ? r_pend : w_filt[i];
        end
    endgenerate

    always_comb begin
        w_valid = |w_out;
        w_id    = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (w_out[i]) begin
                w_id = c_id_w'(i);
            end
        end
    end

    assign auto_out  = w_out;
    assign irq_valid = w_valid;
    assign irq_id    = w_id;

endmodule
`default_nettype wire

// File: tb/tb_int_sync_crossing_sink_filt.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_sync_crossing_sink_filt
// Purpose  : Self-checking bench for the interrupt crossing sink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_sync_crossing_sink_filt;

    localparam logic [3:0] EM = 4'b1010;

    logic       clock        = 1'b0;
    logic       reset        = 1'b0;
    logic [3:0] auto_in_sync = 4'h0;
    logic       irq_ready    = 1'b0;
    logic [3:0] auto_out;
    logic       irq_valid;
    logic [1:0] irq_id;

    int n_checks = 0;
    int n_err    = 0;

    int_sync_crossing_sink_filt #(
        .NUM_INT     (4),
        .SYNC_DEPTH  (3),
        .FILT_CYCLES (4),
        .EDGE_MASK   (EM)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .auto_in_sync (auto_in_sync),
        .auto_out     (auto_out),
        .irq_valid    (irq_valid),
        .irq_id       (irq_id),
        .irq_ready    (irq_ready)
    );

    always #5 clock = ~clock;

    // Reference: s is the input seen three edges earlier; filt follows s once
    // the last four s samples all disagree with it; edge lines latch rises.
    logic [3:0] samp_q[$];
    logic [3:0] s_q[$];
    logic [3:0] m_filt, m_prev, m_pend;

    function automatic logic [3:0] m_out();
        return (EM & m_pend) | (~EM & m_filt);
    endfunction

    function automatic logic [1:0] m_id(input logic [3:0] o);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) if (o[i]) r = 2'(i);
        return r;
    endfunction

    task automatic model_reset();
        samp_q = {4'h0, 4'h0, 4'h0};
        s_q.delete();
        m_filt = 4'h0;
        m_prev = 4'h0;
        m_pend = 4'h0;
    endtask

    task automatic model_tick(input logic [3:0] din, input logic rdy);
        logic [3:0] o, claim, s, nf, np;
        bit         all_diff;
        o     = m_out();
        claim = ((o != 4'h0) && rdy) ? (4'b0001 << m_id(o)) : 4'h0;
        samp_q.push_back(din);
        s = samp_q.pop_front();
        s_q.push_back(s);
        if (s_q.size() > 4) void'(s_q.pop_front());
        nf = m_filt;
        if (s_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < 4; k++) if (s_q[k][i] == m_filt[i]) all_diff = 1'b0;
                if (all_diff) nf[i] = s[i];
            end
        end
        np     = EM & ((m_filt & ~m_prev) | (m_pend & ~claim));
        m_prev = m_filt;
        m_filt = nf;
        m_pend = np;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [3:0] din, input logic rdy);
        logic [3:0] o;
        auto_in_sync = din;
        irq_ready    = rdy;
        @(posedge clock);
        model_tick(din, rdy);
        #1;
        o = m_out();
        chk("model_out", 32'(auto_out), 32'(o));
        chk("model_valid", 32'(irq_valid), 32'(o != 4'h0));
        chk("model_id", 32'(irq_id), 32'(m_id(o)));
        @(negedge clock);
    endtask

    initial begin
        int         first_hi;
        int         hi_cnt;
        logic [3:0] cur;

        model_reset();
        auto_in_sync = 4'hF;
        @(negedge clock);
        @(negedge clock);
        chk("rst_out", 32'(auto_out), 32'h0);
        chk("rst_valid", 32'(irq_valid), 32'h0);
        chk("rst_id", 32'(irq_id), 32'h0);

        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(4'hF, 1'b0);
            if (k == 6) chk("rel_edge6", 32'(auto_out), 32'h0);
            if (k == 7) chk("rel_edge7", 32'(auto_out), 32'h5);
            if (k == 8) chk("rel_edge8", 32'(auto_out), 32'hF);
        end

        // Priority: lines 1 and 3 remain pending after the inputs fall
        for (int k = 0; k < 12; k++) step(4'h0, 1'b0);
        chk("prio_out", 32'(auto_out), 32'hA);
        chk("prio_id1", 32'(irq_id), 32'h1);
        step(4'h0, 1'b1);
        chk("prio_id3", 32'(irq_id), 32'h3);
        chk("prio_out3", 32'(auto_out), 32'h8);
        step(4'h0, 1'b1);
        chk("prio_empty", 32'(irq_valid), 32'h0);
        step(4'h0, 1'b1);
        chk("ready_idle", 32'(auto_out), 32'h0);

        // Glitch: 3-cycle pulse is swallowed
        hi_cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            step((k <= 3) ? 4'h1 : 4'h0, 1'b0);
            if (auto_out[0]) hi_cnt++;
        end
        chk("glitch3_hi", 32'(hi_cnt), 32'h0);

        // 4-cycle pulse passes, high for exactly 4 cycles starting at 7
        hi_cnt   = 0;
        first_hi = 0;
        for (int k = 1; k <= 16; k++) begin
            step((k <= 4) ? 4'h1 : 4'h0, 1'b0);
            if (auto_out[0]) begin
                hi_cnt++;
                if (first_hi == 0) first_hi = k;
            end
        end
        chk("pulse4_first", 32'(first_hi), 32'd7);
        chk("pulse4_len", 32'(hi_cnt), 32'd4);

        // Edge sticky on line 1
        for (int k = 1; k <= 20; k++) begin
            step((k <= 6) ? 4'h2 : 4'h0, 1'b0);
            if (k == 7) chk("edge1_c7", 32'(auto_out[1]), 32'h0);
            if (k == 8) chk("edge1_c8", 32'(auto_out[1]), 32'h1);
        end
        chk("edge1_sticky", 32'(auto_out[1]), 32'h1);
        chk("edge1_id", 32'(irq_id), 32'h1);
        step(4'h0, 1'b1);
        chk("edge1_claim", 32'(auto_out[1]), 32'h0);

        // Set/claim collision on line 3
        for (int k = 1; k <= 20; k++) step((k <= 6) ? 4'h8 : 4'h0, 1'b0);
        chk("coll_pre", 32'(auto_out), 32'h8);
        for (int k = 1; k <= 20; k++) begin
            step((k <= 6) ? 4'h8 : 4'h0, k == 8);
            if (k == 8) chk("coll_keep", 32'(auto_out[3]), 32'h1);
        end
        step(4'h0, 1'b1);
        chk("coll_clear", 32'(auto_out), 32'h0);

        // Reset mid-operation with pending edges and an active count on line 0
        for (int k = 1; k <= 20; k++) step((k <= 6) ? 4'hA : 4'h0, 1'b0);
        chk("mid_pend", 32'(auto_out), 32'hA);
        for (int k = 1; k <= 5; k++) step(4'h1, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_out", 32'(auto_out), 32'h0);
        chk("mid_rst_valid", 32'(irq_valid), 32'h0);
        chk("mid_rst_id", 32'(irq_id), 32'h0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        hi_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step(4'h0, 1'b0);
            if (auto_out != 4'h0) hi_cnt++;
        end
        chk("mid_resume", 32'(hi_cnt), 32'h0);

        // Random stimulus against the reference model
        cur = 4'h0;
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            step(cur, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_sync_crossing_sink_filt.md
# int_sync_crossing_sink_filt

Receive side of the interrupt sync crossing. Takes the registered interrupt vector that the crossing source launches from another clock domain and brings it into the local domain through a flop synchronizer chain. Removes pulses shorter than a programmable width with a per-line glitch filter. Presents each line either as a level or as a sticky edge-pending bit, with a valid/ready claim port that lets the local interrupt controller retire edge interrupts one at a time.

## Interface
- NUM_INT, 4, number of interrupt lines
- SYNC_DEPTH, 3, synchronizer flops per line; legal range 2..4
- FILT_CYCLES, 4, consecutive stable cycles required before the filtered value changes; 0 bypasses the filter
- EDGE_MASK, {NUM_INT{1'b0}}, per line: 1 = rising-edge pending mode, 0 = level mode

- clock  in  1  local domain clock
- reset  in  1  asynchronous, active-low reset; all state clears while low
- auto_in_sync  in  NUM_INT  interrupt vector from the crossing source; asynchronous to clock
- auto_out  out  NUM_INT  per-line interrupt state: the filtered level for level lines, the pending bit for edge lines
- irq_valid  out  1  high when any auto_out bit is 1
- irq_id  out  clog2(NUM_INT) (min 1)  index of the lowest-numbered set auto_out bit; 0 when irq_valid is 0
- irq_ready  in  1  claim from the controller; a transfer occurs when irq_valid && irq_ready

## Operation
- Sync chain, per line: sync[0] <= auto_in_sync[i], then sync[k] <= sync[k-1]. Stage sync[SYNC_DEPTH-1] is the synchronized value s.
- Filter, per line: holds filt and a counter cnt of width clog2(FILT_CYCLES+1).
  - If s == filt: cnt <= 0.
  - If s != filt and cnt == FILT_CYCLES-1: filt <= s and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - FILT_CYCLES = 0: filt <= s every cycle; the counter is absent.
- Level line: auto_out[i] = filt. A claim on the line has no effect on state.
- Edge line: pend is set when filt rises, detected as filt == 1 while the previous filt was 0 (one extra register). A claim with irq_id == i clears pend.
  - Set and claim on the same cycle: set wins and pend stays 1, so no edge is lost.
  - A falling edge on filt does not clear pend.
- Claim port: irq_valid and irq_id are combinational from auto_out, using a fixed lowest-index priority. irq_ready while irq_valid == 0 is ignored.
- Reset low mid-operation: all sync flops, filt, cnt, the edge history and pend clear to 0 asynchronously. Outputs drop within the same cycle. After reset release, an input already high is re-detected as a rising edge.

## Timing
- Reset values: auto_out = 0, irq_valid = 0, irq_id = 0.
- Level line latency, from the first clock edge sampling a changed auto_in_sync to the change on auto_out: SYNC_DEPTH + FILT_CYCLES cycles. Example: 3+4 = 7 cycles.
- Edge line: pend rises 1 cycle after filt rises. Latency is SYNC_DEPTH + FILT_CYCLES + 1 cycles.
- Minimum pulse that passes the filter: FILT_CYCLES consecutive sampled cycles at s. A shorter pulse resets cnt and never reaches filt.
- Claim: pend clears on the edge where irq_valid && irq_ready. irq_id moves to the next set line in the following cycle.
- No combinational path from auto_in_sync to any output. irq_ready reaches only state.

## Structure
- Package int_sync_pkg holds:
  - a clog2 helper function;
  - the legal SYNC_DEPTH bounds;
  - the line-mode constants MODE_LEVEL = 0 and MODE_EDGE = 1.
- One sub-module, int_sync_filt_line: a single line's sync chain and glitch filter, outputting filt. It is instantiated NUM_INT times by a generate loop.
- The top level holds the edge registers, the pending bits and the priority encoder.

## Test plan
All scenarios use NUM_INT = 4, SYNC_DEPTH = 3, FILT_CYCLES = 4, EDGE_MASK = 4'b1010.
- Reset: hold reset low with auto_in_sync = 4'hF → auto_out = 0, irq_valid = 0. Release reset → auto_out[0] and auto_out[2] rise 7 cycles later; bits 1 and 3 rise 8 cycles later.
- Glitch: a 3-cycle high pulse on line 0 → auto_out[0] never rises. A 4-cycle pulse → auto_out[0] is high for exactly 4 cycles, starting 7 cycles after the pulse begins.
- Edge sticky: a 6-cycle pulse on line 1 → auto_out[1] rises at cycle 8 and stays high after the input falls. irq_id = 1. A claim clears it the next cycle.
- Priority: lines 1 and 3 both pending → irq_id = 1. Claim → irq_id = 3. Claim → irq_valid = 0.
- Set/claim collision: a new filtered rising edge on line 3 lands in the same cycle as the claim of line 3 → pend[3] remains 1.
- Reset mid-operation: drive reset low while pend = 4'b1010 and cnt is nonzero on line 0 → all outputs go to 0 immediately. Resume with auto_in_sync = 0 → outputs stay 0.
